// File: rtl/dram_sdp.sv
// Simple-dual-port distributed RAM: synchronous write port and a combinational read port.
// Define DRAM_OUTREG_EN to add a read-first output register, which gives a 1-cycle read latency.
module dram_sdp #(
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_DEPTH      = 16,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  logic [RAM_ADDR_WIDTH-1:0] waddr,
  input  logic [RAM_ADDR_WIDTH-1:0] raddr,
  input  logic [RAM_WIDTH-1:0]      din,
  output logic [RAM_WIDTH-1:0]      dout
);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] rd_data;
  logic                 wr_in_range;
  logic                 rd_in_range;

  // When RAM_DEPTH is not a power of two, the upper addresses are holes.
  // Writes to those addresses are dropped, and reads from them return zero.
  assign wr_in_range = (int'(waddr) < RAM_DEPTH);
  assign rd_in_range = (int'(raddr) < RAM_DEPTH);

  // NOTE: the whole array is cleared asynchronously, so it must be built from flops rather than LUT RAM;
  // every word has to read zero as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wen && wr_in_range) begin
      mem_q[waddr] <= din;
    end
  end

  assign rd_data = rd_in_range ? mem_q[raddr] : '0;

`ifdef DRAM_OUTREG_EN
  logic [RAM_WIDTH-1:0] dout_q;
  logic [RAM_WIDTH-1:0] dout_d;

  // The register samples the array before the same-edge write lands, so the read is read-first.
  assign dout_d = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  assign dout = rd_data;
`endif

endmodule

// File: tb/tb_dram_sdp.sv
// Scoreboard bench for dram_sdp: a full-depth instance and a 12-deep instance share one stimulus stream.
// Both instances are checked against array reference models.
module tb_dram_sdp;

  localparam int W   = 32;
  localparam int AW  = 4;
  localparam int D16 = 16;
  localparam int D12 = 12;

  logic          clk;
  logic          rst_n;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [W-1:0]  din;
  logic [W-1:0]  dout16;
  logic [W-1:0]  dout12;

  dram_sdp #(.RAM_WIDTH(W), .RAM_DEPTH(D16), .RAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr),
    .raddr(raddr), .din(din), .dout(dout16)
  );

  dram_sdp #(.RAM_WIDTH(W), .RAM_DEPTH(D12), .RAM_ADDR_WIDTH(AW)) dut12 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr),
    .raddr(raddr), .din(din), .dout(dout12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] e16;
    logic [W-1:0] e12;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model16 [D16];
  logic [W-1:0] model12 [D12];
  int           n_checks = 0;
  int           n_errors = 0;
  bit           rd_valid = 1'b0;
  bit           rd_valid_d = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rd16(input logic [AW-1:0] a);
    return model16[a];
  endfunction

  function automatic logic [W-1:0] rd12(input logic [AW-1:0] a);
    return (int'(a) < D12) ? model12[int'(a)] : '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D16; i++) model16[i] = '0;
    for (int i = 0; i < D12; i++) model12[i] = '0;
  endtask

  // Called at posedge+1. Presents one cycle of traffic and queues the expected read.
  // The read value is always the array state before this cycle's write edge.
  task automatic drive(input bit w, input logic [AW-1:0] wa, input logic [W-1:0] d,
                       input logic [AW-1:0] ra);
    exp_t e;
    wen = w; waddr = wa; din = d; raddr = ra; rd_valid = 1'b1;
    e.e16 = rd16(ra);
    e.e12 = rd12(ra);
    exp_q.push_back(e);
    @(posedge clk);
    if (w) begin
      model16[wa] = d;
      if (int'(wa) < D12) model12[int'(wa)] = d;
    end
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; rd_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rd_valid_d <= rd_valid;

  // Monitor: read data appears in the same cycle, or one cycle later when the output register is present.
  always @(negedge clk) begin
    bit   mon_en;
    exp_t e;
`ifdef DRAM_OUTREG_EN
    mon_en = rd_valid_d;
`else
    mon_en = rd_valid;
`endif
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got read with empty queue, expected a queued read");
      end else begin
        e = exp_q.pop_front();
        check("rd16", dout16, e.e16);
        check("rd12", dout12, e.e12);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wen = 1'b0; waddr = '0; raddr = 4'd7; din = '0;
    rst_n = 1'b1;
    model_clear();
    #1 rst_n = 1'b0;
    #2;
    check("reset_dout16", dout16, '0);
    check("reset_dout12", dout12, '0);
    raddr = 4'd13;
    #1;
    check("reset_dout16_a13", dout16, '0);
    check("reset_dout12_a13", dout12, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < D16; i++) drive(1'b0, '0, '0, AW'(i));

    for (int i = 0; i < D16; i++) drive(1'b1, AW'(i), W'((i + 1) << 1), AW'((i + 7) % D16));
    for (int i = 0; i < D16; i++) drive(1'b0, '0, '0, AW'(i));

    drive(1'b0, 4'd3, 32'hDEADBEEF, 4'd3);
    drive(1'b0, 4'd0, '0, 4'd3);

    drive(1'b1, 4'd5, 32'h55, 4'd5);
    drive(1'b0, 4'd0, '0, 4'd5);

    drive(1'b1, 4'd13, 32'hCAFE0013, 4'd13);
    drive(1'b0, 4'd0, '0, 4'd13);
    drive(1'b0, 4'd0, '0, 4'd1);

    idle();
    idle();
    raddr = 4'd2;
    #3 rst_n = 1'b0;
    #1;
    check("midreset_dout16", dout16, '0);
    check("midreset_dout12", dout12, '0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < D16; i++) drive(1'b0, '0, '0, AW'(i));

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = AW'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      drive(1'($urandom_range(0, 1)), wa, $urandom, ra);
    end

    idle();
    idle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
